// File: rtl/present_dec_core_if.sv
// present_dec_core_if
// -------------------
// Request/response bundle for the PRESENT-80 decryption core.
//   start_i : request strobe, taken only while ready_o is high
//   data_i  : 64-bit ciphertext, sampled on the accepting edge
//   key_i   : 80-bit user key, sampled on the accepting edge
//   ready_o : core is idle and will take a request
//   valid_o : one-cycle pulse, data_o carries a fresh plaintext
//   data_o  : 64-bit plaintext, held until the next result
// The master modport is the requester; the slave modport is the core.
`timescale 1ns/1ps

interface present_dec_core_if;
    logic        start_i;
    logic [63:0] data_i;
    logic [79:0] key_i;
    logic        ready_o;
    logic        valid_o;
    logic [63:0] data_o;

    modport master (
        output start_i,
        output data_i,
        output key_i,
        input  ready_o,
        input  valid_o,
        input  data_o
    );

    modport slave (
        input  start_i,
        input  data_i,
        input  key_i,
        output ready_o,
        output valid_o,
        output data_o
    );
endinterface

// File: rtl/present_dec_core.sv
// present_dec_core
// ----------------
// Iterative PRESENT-80 decryption. The key schedule is first run forward
// to reach the last round key, the state is whitened with it, and the
// rounds are then undone one per cycle (inverse pLayer, inverse S-box
// layer, XOR with the round key recovered by stepping the schedule back).
//   clk_i   : system clock, rising edge
//   rst_n_i : asynchronous active-low reset
//   bus     : present_dec_core_if.slave (start/data/key in, ready/valid/data out)
`timescale 1ns/1ps

module present_dec_core #(
    parameter int ROUNDS = 31
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    present_dec_core_if.slave  bus
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_KEYGEN = 3'd1;
    localparam logic [2:0] ST_WHITEN = 3'd2;
    localparam logic [2:0] ST_DEC    = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

    logic [2:0]  fsm_q,   fsm_d;
    logic [63:0] state_q, state_d;
    logic [79:0] key_q,   key_d;
    logic [4:0]  cnt_q,   cnt_d;
    logic [63:0] data_q,  data_d;
    logic        valid_q, valid_d;

    logic [79:0] key_fwd;
    logic [79:0] key_bwd;
    logic [63:0] state_dec;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
            4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
            4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
            4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
        endcase
        return y;
    endfunction

    function automatic logic [63:0] sinv_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int j = 0; j < 16; j++) begin
            y[6'(4*j) +: 4] = sbox_inv(x[6'(4*j) +: 4]);
        end
        return y;
    endfunction

    // The forward pLayer sends bit i to 16*i mod 63, so the inverse
    // simply gathers each output bit from that position.
    function automatic logic [63:0] pinv_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 63; i++) begin
            y[6'(i)] = x[6'((16*i) % 63)];
        end
        y[63] = x[63];
        return y;
    endfunction

    // Forward schedule step: rotate left 61, S-box the top nibble,
    // fold the round counter into bits [19:15].
    always_comb begin
        logic [79:0] rot;
        rot     = {key_q[18:0], key_q[79:19]};
        key_fwd = {sbox(rot[79:76]), rot[75:20], rot[19:15] ^ cnt_q, rot[14:0]};
    end

    // Backward schedule step, undoing the forward one in reverse order:
    // remove the counter, invert the top nibble, rotate right 61.
    always_comb begin
        logic [79:0] t;
        t       = {key_q[79:20], key_q[19:15] ^ cnt_q, key_q[14:0]};
        t       = {sbox_inv(t[79:76]), t[75:0]};
        key_bwd = {t[60:0], t[79:61]};
    end

    assign state_dec = sinv_layer(pinv_layer(state_q)) ^ key_bwd[79:16];

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_d = bus.data_i;
                    key_d   = bus.key_i;
                    cnt_d   = 5'd1;
                    fsm_d   = ST_KEYGEN;
                end
            end
            ST_KEYGEN: begin
                key_d = key_fwd;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_ROUND) begin
                    fsm_d = ST_WHITEN;
                end
            end
            ST_WHITEN: begin
                state_d = state_q ^ key_q[79:16];
                cnt_d   = LAST_ROUND;
                fsm_d   = ST_DEC;
            end
            ST_DEC: begin
                state_d = state_dec;
                key_d   = key_bwd;
                cnt_d   = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    fsm_d = ST_DONE;
                end
            end
            ST_DONE: begin
                data_d  = state_q;
                valid_d = 1'b1;
                fsm_d   = ST_IDLE;
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            key_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign bus.ready_o = (fsm_q == ST_IDLE);
    assign bus.valid_o = valid_q;
    assign bus.data_o  = data_q;

endmodule

// File: tb/tb_present_dec_core.sv
// tb_present_dec_core
// -------------------
// Self-checking bench for present_dec_core. Expected plaintexts go into a
// scoreboard queue when a request is issued and are popped when valid_o
// fires. Random vectors are produced with an independent encryption model.
`timescale 1ns/1ps

module tb_present_dec_core;

    logic clk;
    logic rst_n;

    present_dec_core_if bus ();

    present_dec_core #(.ROUNDS(31)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int valid_total = 0;
    logic [63:0] exp_q [$];

    always @(negedge clk) begin
        if (bus.valid_o === 1'b1) valid_total++;
    end

    function automatic logic [3:0] m_sbox(input logic [3:0] x);
        logic [63:0] tbl;
        tbl = 64'h21748FE3DA09B65C;
        return tbl[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [63:0] m_encrypt(input logic [63:0] pt, input logic [79:0] k);
        logic [63:0] s, p;
        logic [79:0] key;
        s = pt;
        key = k;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ key[79:16];
            for (int j = 0; j < 16; j++) s[j*4 +: 4] = m_sbox(s[j*4 +: 4]);
            p = '0;
            for (int i = 0; i < 64; i++) p[(i == 63) ? 63 : (16*i) % 63] = s[i];
            s = p;
            key = {key[18:0], key[79:19]};
            key[79:76] = m_sbox(key[79:76]);
            key[19:15] = key[19:15] ^ 5'(r);
        end
        return s ^ key[79:16];
    endfunction

    // Issue one request (caller sits #1 after an edge with ready high) and
    // wait a bounded time for valid_o. lat = -1 means it never came.
    task automatic run_one(input logic [63:0] ct, input logic [79:0] k,
                           output int lat, output logic [63:0] got);
        bus.start_i = 1'b1;
        bus.data_i  = ct;
        bus.key_i   = k;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        bus.data_i  = {$urandom, $urandom};
        bus.key_i   = {$urandom, $urandom, 16'($urandom)};
        lat = -1;
        got = '0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (bus.valid_o === 1'b1) begin
                lat = c;
                got = bus.data_o;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start_i = 1'b0;
        bus.data_i  = '0;
        bus.key_i   = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.data_o !== 64'h0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: ready=%b valid=%b data=%h, required ready=1 valid=0 data=0",
                     bus.ready_o, bus.valid_o, bus.data_o);
        end
        checks++;
        if (dut.state_q !== 64'h0 || dut.key_q !== 80'h0 || dut.cnt_q !== 5'd0) begin
            failures++;
            $display("[TB] FAIL reset_regs: state=%h key=%h cnt=%0d, required all zero",
                     dut.state_q, dut.key_q, dut.cnt_q);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL after_reset: ready=%b valid=%b, required ready=1 valid=0",
                     bus.ready_o, bus.valid_o);
        end
    endtask

    task automatic test_known_vectors();
        logic [63:0] ct [2];
        logic [79:0] k  [2];
        int lat;
        logic [63:0] got, exp;
        ct[0] = 64'h5579C1387B228445;  k[0] = 80'h0;
        ct[1] = 64'hE72C46C0F5945049;  k[1] = {80{1'b1}};
        for (int v = 0; v < 2; v++) begin
            exp_q.push_back(64'h0);
            run_one(ct[v], k[v], lat, got);
            exp = exp_q.pop_front();
            checks++;
            if (lat != 64) begin
                failures++;
                $display("[TB] FAIL vec%0d_latency: got %0d cycles, required 64", v, lat);
            end
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL vec%0d_data: got %h, required %h", v, got, exp);
            end
            checks++;
            if (dut.key_q !== k[v]) begin
                failures++;
                $display("[TB] FAIL vec%0d_key_k1: got %h, required %h", v, dut.key_q, k[v]);
            end
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [63:0] got, exp;
        exp_q.push_back({64{1'b1}});
        run_one(64'hA112FFC72F68417B, 80'h0, lat, got);
        exp = exp_q.pop_front();
        checks++;
        if (lat != 64 || got !== exp) begin
            failures++;
            $display("[TB] FAIL b2b_first: lat=%0d data=%h, required lat=64 data=%h", lat, got, exp);
        end
        checks++;
        if (bus.ready_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_ready_on_valid: ready=%b, required 1", bus.ready_o);
        end
        exp_q.push_back({64{1'b1}});
        run_one(64'h3333DCD3213210D2, {80{1'b1}}, lat, got);
        exp = exp_q.pop_front();
        checks++;
        if (lat != 64 || got !== exp) begin
            failures++;
            $display("[TB] FAIL b2b_second: lat=%0d data=%h, required lat=64 data=%h", lat, got, exp);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_busy_start();
        int ready_hi = 0;
        int valids   = 0;
        int lat      = -1;
        logic [63:0] got = '0;
        logic [63:0] exp;
        exp_q.push_back(64'h0);
        bus.start_i = 1'b1;
        bus.data_i  = 64'h5579C1387B228445;
        bus.key_i   = 80'h0;
        @(posedge clk); #1;
        for (int c = 1; c <= 150; c++) begin
            if (bus.start_i) begin
                bus.data_i = {$urandom, $urandom};
                bus.key_i  = {$urandom, $urandom, 16'($urandom)};
            end
            @(posedge clk); #1;
            if (c < 64 && bus.ready_o !== 1'b0) ready_hi++;
            if (bus.valid_o === 1'b1) begin
                valids++;
                if (lat < 0) begin
                    lat = c;
                    got = bus.data_o;
                end
                bus.start_i = 1'b0;
            end
        end
        exp = exp_q.pop_front();
        checks++;
        if (ready_hi != 0) begin
            failures++;
            $display("[TB] FAIL busy_ready_low: ready high in %0d busy cycles, required 0", ready_hi);
        end
        checks++;
        if (valids != 1 || lat != 64) begin
            failures++;
            $display("[TB] FAIL busy_single_valid: %0d pulses first at %0d, required 1 at 64", valids, lat);
        end
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL busy_data: got %h, required %h", got, exp);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        int stray = 0;
        logic [63:0] got, exp;
        exp_q.push_back({64{1'b1}});
        run_one(64'hA112FFC72F68417B, 80'h0, lat, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL abort_setup: got %h, required %h", got, exp);
        end
        bus.start_i = 1'b1;
        bus.data_i  = 64'hE72C46C0F5945049;
        bus.key_i   = {80{1'b1}};
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.data_o !== 64'h0) begin
            failures++;
            $display("[TB] FAIL abort_outputs: ready=%b valid=%b data=%h, required ready=1 valid=0 data=0",
                     bus.ready_o, bus.valid_o, bus.data_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            if (bus.valid_o !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("[TB] FAIL abort_no_output: %0d valid cycles, required 0", stray);
        end
        exp_q.push_back(64'h0);
        run_one(64'h5579C1387B228445, 80'h0, lat, got);
        exp = exp_q.pop_front();
        checks++;
        if (lat != 64 || got !== exp) begin
            failures++;
            $display("[TB] FAIL abort_recover: lat=%0d data=%h, required lat=64 data=%h", lat, got, exp);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_random_roundtrip();
        int lat;
        int bad = 0;
        int accepted = 0;
        int v0;
        logic [63:0] pt, got, exp;
        logic [79:0] k;
        v0 = valid_total;
        for (int n = 0; n < 1000; n++) begin
            pt = {$urandom, $urandom};
            k  = {$urandom, $urandom, 16'($urandom)};
            exp_q.push_back(pt);
            accepted++;
            run_one(m_encrypt(pt, k), k, lat, got);
            exp = exp_q.pop_front();
            if (lat != 64 || got !== exp) begin
                bad++;
                if (bad <= 5)
                    $display("[TB] FAIL random_%0d: lat=%0d data=%h, required lat=64 data=%h",
                             n, lat, got, exp);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL random_roundtrip: %0d of 1000 wrong, required 0", bad);
        end
        checks++;
        if (valid_total - v0 != accepted) begin
            failures++;
            $display("[TB] FAIL random_valid_count: got %0d, required %0d", valid_total - v0, accepted);
        end
    endtask

    initial begin
        test_reset();
        test_known_vectors();
        test_back_to_back();
        test_busy_start();
        test_reset_abort();
        test_random_roundtrip();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/present_dec_core.md
Name: present_dec_core

Overview:
- Iterative PRESENT-80 decryption core: the inverse of the encryption datapath.
- Takes a 64-bit ciphertext and an 80-bit user key (the same key given to the encryptor) and returns the 64-bit plaintext.
- Runs the key schedule forward to recover the final round key, then executes the rounds in reverse: inverse pLayer, inverse sBoxLayer, round-key XOR.
- Instantiates 16 inverse S-box lanes for the state and one forward S-box for the key schedule; sits beside the encryption core in the cipher top level.

Parameters:
ROUNDS, 31, number of full rounds. Round keys K1..K(ROUNDS+1) are used; the counter is 5 bits wide, so ROUNDS is at most 31.

Ports:
clk_i  input  1  system clock, all state updates on rising edge
rst_n_i  input  1  asynchronous active-low reset
start_i  input  1  request; accepted only when ready_o=1
data_i  input  64  ciphertext, sampled on the accepting edge
key_i  input  80  user key (K1 source), sampled on the accepting edge
ready_o  output  1  high in IDLE only
valid_o  output  1  one-cycle pulse: data_o holds a new plaintext
data_o  output  64  plaintext; held until the next accepted start

Behaviour:
- Reset (asynchronous, active-low) sets: FSM=IDLE, ready_o=1, valid_o=0, data_o=0, state register=0, key register=0, round counter=0.
- Reset asserted mid-operation aborts immediately; there is no partial output.
- FSM states: IDLE, KEYGEN, WHITEN, DEC, DONE.
- IDLE: ready_o=1. On an edge with start_i=1: state<=data_i, key<=key_i, cnt<=1, go to KEYGEN.
- KEYGEN: forward key update each cycle, then cnt++:
  - key<=rotl61(key);
  - key[79:76]<=S(key[79:76]);
  - key[19:15]^=cnt.
  - When cnt==ROUNDS (the last update), go to WHITEN. The key register now holds K(ROUNDS+1).
- WHITEN: state<=state^key[79:16]; cnt<=ROUNDS; go to DEC.
- DEC: first compute kp = inverse key update of the key register, combinationally:
  - key[19:15]^=cnt;
  - key[79:76]=Sinv(key[79:76]);
  - rotr61.
  - kp is K(cnt).
  - Register updates: state<=SinvLayer(PinvLayer(state))^kp[79:16]; key<=kp; cnt--.
  - When cnt==1, go to DONE.
- PinvLayer: output bit i = input bit P(i), where P(i)=16*i mod 63 for i<63 and P(63)=63.
- SinvLayer: 16 parallel 4-bit inverse S-box lanes, nibble j maps to nibble j.
- DONE: data_o<=state, valid_o=1 for exactly this one cycle, then go to IDLE.
- Latency: accepting edge at cycle 0; valid_o is high during the cycle following edge ROUNDS+1+ROUNDS+1, i.e. 64 for ROUNDS=31. Next start is accepted no earlier than the cycle after the valid_o pulse.
- Busy-cycle rules:
  - start_i while not in IDLE is ignored, not queued.
  - data_i and key_i changes after acceptance have no effect.
- Counter XOR uses 5-bit cnt aligned to key bits [19:15]; there is no wrap because cnt stays within 1..31.
- After valid_o, the key register holds K1, which equals the user key; the bench may probe this internally.

Test Plan:
- Reset then start: key=0, data_i=64'h5579C1387B228445 -> valid_o pulse at cycle 64, data_o=64'h0000000000000000.
- key=80'hFFFF_FFFFFFFF_FFFFFFFF, data_i=64'hE72C46C0F5945049 -> data_o=64'h0000000000000000.
- key=0, data_i=64'hA112FFC72F68417B -> data_o=64'hFFFFFFFFFFFFFFFF. Then, back-to-back, key=all ones, data_i=64'h3333DCD3213210D2 -> data_o=all ones.
- start_i held high with changing data_i during a run -> only the first request is processed; ready_o stays 0 for 64 cycles; exactly one valid_o pulse; data_o is correct for the first ciphertext.
- rst_n_i pulsed low at cycle 40 of a run -> outputs return immediately to ready_o=1, valid_o=0, data_o=0. A following start with vector 1 decrypts correctly.
- Random 1k key/ciphertext pairs checked against a reference model (encrypt → decrypt round trip) -> data_o equals the original plaintext every time, and valid_o count equals the accepted start count.
